// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed scanner for a common-anode seven-segment display.
//
// Holds a packed hex value and cycles through its digits. Each digit gets a
// slot of DWELL cycles. The first BLANK cycles of a slot keep every anode off
// to prevent ghosting. A newly loaded value is applied only at the frame
// boundary, so the display never shows a mix of old and new digits.
//
// Optional feature: define SEG_SCAN_LZB_EN to enable leading-zero blanking.
// Digits above the most significant nonzero nibble then keep their anode off.
// Digit 0 is always shown.
//
// Parameters:
//   DIGITS     number of digits scanned (1..8)
//   DWELL      clock cycles per digit slot (>= 2)
//   BLANK      guard cycles at the start of each slot (0..DWELL-1)
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   value      packed hex value, digit i = value[4*i+3:4*i], digit 0 rightmost
//   load       one-cycle strobe that captures value
//   num        nibble of the digit currently being scanned (to the decoder)
//   an         active-low anode enables, at most one bit low
//   frame_done high during the last cycle of the last slot of a frame
module seg_scan #(
  parameter int DIGITS = 8,
  parameter int DWELL  = 50000,
  parameter int BLANK  = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  output logic [3:0]            num,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int DW = ($clog2(DWELL) < 1) ? 1 : $clog2(DWELL);
  localparam int IW = ($clog2(DIGITS) < 1) ? 1 : $clog2(DIGITS);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  logic [DW-1:0]          dwell;
  logic [IW-1:0]          idx;
  logic [4*DIGITS-1:0]    pending;
  logic [4*DIGITS-1:0]    active;
  logic                   pend_v;
  logic                   slot_end;
  logic                   frame_end;
  logic                   in_guard;
  logic                   shown;

  assign slot_end  = (dwell == DWELL_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // Slot timing and digit index counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell <= '0;
      idx   <= '0;
    end else begin
      if (slot_end) begin
        dwell <= '0;
        if (idx == IDX_LAST) begin
          idx <= '0;
        end else begin
          idx <= idx + IW'(1);
        end
      end else begin
        dwell <= dwell + DW'(1);
      end
    end
  end

  // Pending capture and tear-free transfer into the displayed value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      pend_v  <= 1'b0;
      active  <= '0;
    end else begin
      if (load) begin
        pending <= value;
      end
      if (frame_end) begin
        // A load coinciding with the boundary bypasses pending.
        if (load) begin
          active <= value;
        end else if (pend_v) begin
          active <= pending;
        end
        pend_v <= 1'b0;
      end else if (load) begin
        pend_v <= 1'b1;
      end
    end
  end

  // Guard interval decode; with no guard the comparison would be vacuous.
  generate
    if (BLANK == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      localparam logic [DW-1:0] BLANK_W = DW'(BLANK);
      assign in_guard = (dwell < BLANK_W);
    end
  endgenerate

`ifdef SEG_SCAN_LZB_EN
  logic [IW-1:0] msd;

  // Index of the most significant nonzero nibble (0 when active is zero).
  always_comb begin
    msd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (active[4*i +: 4] != 4'h0) begin
        msd = IW'(i);
      end else begin
        msd = msd;
      end
    end
  end

  assign shown = (idx <= msd);
`else
  assign shown = 1'b1;
`endif

  // Nibble select for the current digit.
  always_comb begin
    num = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        num = active[4*i +: 4];
      end else begin
        num = num;
      end
    end
  end

  // Anode decode: only the current digit, only after the guard interval.
  always_comb begin
    an = {DIGITS{1'b1}};
    for (int i = 0; i < DIGITS; i++) begin
      if (!in_guard && shown && (idx == IW'(i))) begin
        an[i] = 1'b0;
      end else begin
        an[i] = 1'b1;
      end
    end
  end

  assign frame_done = frame_end;

endmodule

// File: tb/tb_seg_scan.sv
module tb_seg_scan;
  localparam int DIGITS = 4;
  localparam int DWELL  = 4;
  localparam int BLANK  = 1;
  localparam int FRAME  = DIGITS * DWELL;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic [3:0]  num;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  // Reference model state: t counts rising edges since reset release.
  int          t;
  logic [15:0] m_active;
  logic [15:0] m_pend;
  logic        m_pv;
  logic [3:0]  e_num;
  logic [3:0]  e_an;
  logic        e_fd;

  always #5 clk = ~clk;

  seg_scan #(.DIGITS(DIGITS), .DWELL(DWELL), .BLANK(BLANK)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .num(num), .an(an), .frame_done(frame_done)
  );

  // Expected outputs for the current cycle, from plain arithmetic on t.
  task automatic model_eval;
    int slot;
    int dw;
    logic show;
    slot = (t / DWELL) % DIGITS;
    dw = t % DWELL;
    e_num = 4'((m_active >> (4 * slot)) & 16'h000F);
`ifdef SEG_SCAN_LZB_EN
    begin
      int msd;
      msd = 0;
      for (int i = 0; i < DIGITS; i++)
        if (((m_active >> (4 * i)) & 16'h000F) != 16'h0000) msd = i;
      show = (slot <= msd);
    end
`else
    show = 1'b1;
`endif
    e_an = 4'b1111;
    if (dw >= BLANK && show) e_an[slot] = 1'b0;
    e_fd = ((t % FRAME) == FRAME - 1);
  endtask

  // Drive one cycle of inputs, advance the model across the edge.
  task automatic tick(input logic ld, input logic [15:0] v);
    logic boundary;
    load = ld;
    value = v;
    @(posedge clk);
    boundary = ((t % FRAME) == FRAME - 1);
    if (boundary) begin
      if (ld) m_active = v;
      else if (m_pv) m_active = m_pend;
      m_pv = 1'b0;
    end else if (ld) begin
      m_pv = 1'b1;
    end
    if (ld) m_pend = v;
    t++;
    @(negedge clk);
    load = 1'b0;
    model_eval();
  endtask

  task automatic release_reset;
    @(negedge clk);
    rst = 1'b0;
    t = 0;
    m_active = 16'h0000;
    m_pend = 16'h0000;
    m_pv = 1'b0;
    model_eval();
  endtask

  task automatic apply_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    release_reset();
  endtask

  task automatic align_to(input int phase);
    while ((t % FRAME) != phase) tick(1'b0, 16'h0000);
  endtask

  task automatic test_reset;
    apply_reset();
    tick(1'b1, 16'h9ABC);
    while (t < 18) tick(1'b0, 16'h0000);
    // Mid-slot: digit 0 of the loaded value is lit here.
    rst = 1'b1;
    #1;
    checks++;
    if (an !== 4'b1111) begin failures++; $display("FAIL reset_an got=%b exp=1111", an); end
    checks++;
    if (num !== 4'h0) begin failures++; $display("FAIL reset_num got=%h exp=0", num); end
    checks++;
    if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
    release_reset();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (an !== ((k == 0) ? 4'b1111 : 4'b1110)) begin
        failures++; $display("FAIL reset_first_slot_an k=%0d got=%b", k, an);
      end
      checks++;
      if (num !== 4'h0) begin failures++; $display("FAIL reset_first_slot_num k=%0d got=%h exp=0", k, num); end
      tick(1'b0, 16'h0000);
    end
  endtask

  task automatic test_deferred_load;
    logic [3:0] xn;
    logic [3:0] xa;
    apply_reset();
    for (int c = 0; c < 24; c++) begin
      if (c < 16) begin
        xn = 4'h0; xa = e_an;
      end else if (c < 20) begin
        xn = 4'h4; xa = (c == 16) ? 4'b1111 : 4'b1110;
      end else begin
        xn = 4'h3; xa = (c == 20) ? 4'b1111 : 4'b1101;
      end
      checks++;
      if (num !== xn) begin failures++; $display("FAIL deferred_num c=%0d got=%h exp=%h", c, num, xn); end
      checks++;
      if (an !== xa) begin failures++; $display("FAIL deferred_an c=%0d got=%b exp=%b", c, an, xa); end
      checks++;
      if (frame_done !== (c == 15)) begin
        failures++; $display("FAIL deferred_fd c=%0d got=%b exp=%b", c, frame_done, (c == 15));
      end
      tick(c == 2, 16'h1234);
    end
  endtask

  task automatic test_last_load_wins;
    align_to(0);
    for (int c = 0; c < 2 * FRAME; c++) begin
      if (c >= FRAME) begin
        checks++;
        if (num !== 4'h5) begin failures++; $display("FAIL lastload_num c=%0d got=%h exp=5", c, num); end
      end
      checks++;
      if (an !== e_an) begin failures++; $display("FAIL lastload_an c=%0d got=%b exp=%b", c, an, e_an); end
      if (c == 3) tick(1'b1, 16'hAAAA);
      else if (c == 9) tick(1'b1, 16'h5555);
      else tick(1'b0, 16'h0000);
    end
  endtask

  task automatic test_boundary_coincidence;
    logic [15:0] v;
    logic [3:0]  xn;
    v = 16'hBEEF;
    align_to(2);
    tick(1'b1, 16'h1111);
    align_to(FRAME - 1);
    checks++;
    if (frame_done !== 1'b1) begin failures++; $display("FAIL boundary_fd got=%b exp=1", frame_done); end
    tick(1'b1, v);
    for (int c = 0; c < FRAME; c++) begin
      xn = 4'((v >> (4 * (c / DWELL))) & 16'h000F);
      checks++;
      if (num !== xn) begin failures++; $display("FAIL boundary_num c=%0d got=%h exp=%h", c, num, xn); end
      checks++;
      if (an !== e_an) begin failures++; $display("FAIL boundary_an c=%0d got=%b exp=%b", c, an, e_an); end
      tick(1'b0, 16'h0000);
    end
  endtask

  task automatic test_reset_pending;
    align_to(1);
    tick(1'b1, 16'h7777);
    tick(1'b0, 16'h0000);
    rst = 1'b1;
    @(negedge clk);
    release_reset();
    for (int c = 0; c < 2 * FRAME; c++) begin
      checks++;
      if (num !== 4'h0) begin failures++; $display("FAIL rstpend_num c=%0d got=%h exp=0", c, num); end
      checks++;
      if (an !== e_an) begin failures++; $display("FAIL rstpend_an c=%0d got=%b exp=%b", c, an, e_an); end
      tick(1'b0, 16'h0000);
    end
  endtask

  task automatic test_lzb;
    align_to(FRAME - 1);
    tick(1'b1, 16'h0030);
    for (int c = 0; c < FRAME; c++) begin
      checks++;
      if (num !== e_num) begin failures++; $display("FAIL lzb30_num c=%0d got=%h exp=%h", c, num, e_num); end
      checks++;
      if (an !== e_an) begin failures++; $display("FAIL lzb30_an c=%0d got=%b exp=%b", c, an, e_an); end
`ifdef SEG_SCAN_LZB_EN
      checks++;
      if (an[3:2] !== 2'b11) begin failures++; $display("FAIL lzb30_hi c=%0d got=%b exp=11", c, an[3:2]); end
`endif
      tick(1'b0, 16'h0000);
    end
    align_to(FRAME - 1);
    tick(1'b1, 16'h0000);
    for (int c = 0; c < FRAME; c++) begin
      checks++;
      if (an !== e_an) begin failures++; $display("FAIL lzb0_an c=%0d got=%b exp=%b", c, an, e_an); end
`ifdef SEG_SCAN_LZB_EN
      checks++;
      if (an[3:1] !== 3'b111) begin failures++; $display("FAIL lzb0_hi c=%0d got=%b exp=111", c, an[3:1]); end
`endif
      tick(1'b0, 16'h0000);
    end
  endtask

  task automatic test_random;
    logic        ld;
    logic [15:0] v;
    for (int c = 0; c < 400; c++) begin
      checks++;
      if (num !== e_num) begin failures++; $display("FAIL rand_num t=%0d got=%h exp=%h", t, num, e_num); end
      checks++;
      if (an !== e_an) begin failures++; $display("FAIL rand_an t=%0d got=%b exp=%b", t, an, e_an); end
      checks++;
      if (frame_done !== e_fd) begin failures++; $display("FAIL rand_fd t=%0d got=%b exp=%b", t, frame_done, e_fd); end
      ld = ($urandom_range(0, 5) == 0) || (e_fd && ($urandom_range(0, 1) == 0));
      v = 16'($urandom);
      tick(ld, v);
    end
  endtask

  initial begin
    rst = 1'b1;
    load = 1'b0;
    value = 16'h0000;
    t = 0;
    m_active = 16'h0000;
    m_pend = 16'h0000;
    m_pv = 1'b0;
    test_reset();
    test_deferred_load();
    test_last_load_wins();
    test_boundary_coincidence();
    test_reset_pending();
    test_lzb();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
# seg_scan

Time-multiplexed scanner for a common-anode multi-digit seven-segment display. Holds a packed hex value and cycles through its digits, presenting one 4-bit nibble per slot to the downstream hex-to-segment decoder (`num` in, active-low `seg` out) and driving the matching active-low digit anode. Display updates are tear-free: a new value is taken only at a frame boundary. A guard interval at the start of each slot prevents ghosting.

## Interface
- `DIGITS`, 8: number of digits scanned, 1..8.
- `DWELL`, 50000: clock cycles per digit slot, at least 2.
- `BLANK`, 500: guard cycles at the start of each slot with all anodes off, 0..DWELL-1.

- `clk`, in, 1: single clock; all state changes on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `value`, in, 4*DIGITS: packed hex value; digit i is `value[4*i+3:4*i]`, and digit 0 is rightmost.
- `load`, in, 1: one-cycle strobe that captures `value`.
- `num`, out, 4: current digit nibble, fed directly to the decoder.
- `an`, out, DIGITS: active-low anode enables, at most one bit low.
- `frame_done`, out, 1: high during the last cycle of the last slot of a frame.

## Operation
- State:
  - `dwell` counter, 0..DWELL-1.
  - digit index `idx`, 0..DIGITS-1.
  - `pending` register and `pend_v` flag.
  - `active` register, which is the displayed value.
- Each cycle `dwell` increments. At `dwell==DWELL-1`:
  - `dwell` returns to 0.
  - `idx` advances to `idx+1`, wrapping from DIGITS-1 to 0.
- Frame boundary: `idx==DIGITS-1` and `dwell==DWELL-1`, which is the same condition as `frame_done`.
- `load` high in any cycle: `pending` takes `value` and `pend_v` is set. With multiple loads in one frame, the last one wins.
- At the frame-boundary edge:
  - If `load` is high, `active` takes `value` directly. The same-cycle load wins over `pending`.
  - Otherwise, if `pend_v` is set, `active` takes `pending`.
  - In both cases `pend_v` clears.
- `num` equals `active[4*idx+3:4*idx]` during the whole slot, guard included.
- `an[idx]` is 0 when `dwell >= BLANK`; all other bits are 1. With BLANK=0 the anode is on for the whole slot.
- No combinational path from any input to any output. Outputs are flops or decode of flops only.
- Reset mid-frame aborts the scan immediately and discards any pending value.

## Timing
- Reset values:
  - Outputs: `an` all ones, `num`=0, `frame_done`=0.
  - Internal: `dwell`=0, `idx`=0, `active`=0, `pending`=0, `pend_v`=0.
- The first slot after reset release is digit 0, starting at `dwell` 0.
- Frame length is DIGITS×DWELL cycles. The anode is on for DWELL−BLANK cycles per slot.
- Load-to-display latency:
  - Minimum: 1 cycle, when `load` coincides with `frame_done`.
  - Maximum: DIGITS×DWELL cycles.
- `frame_done` is high for exactly 1 cycle per frame.
- With DIGITS=1, every slot is the last slot of its frame, so `frame_done` pulses every DWELL cycles.
- Counter widths are `$clog2(DWELL)` and `$clog2(DIGITS)` (minimum 1), with no overflow beyond the stated wrap points.

## Configuration
- `SEG_SCAN_LZB_EN` (leading-zero blanking).
- Defined: digits above the most significant nonzero nibble of `active` keep their anode bit 1 for the whole slot. The scan timing is unchanged. Digit 0 is always shown, so `active`=0 displays a single "0".
- Undefined: all DIGITS digits are shown, including leading zeros.

## Test plan
All scenarios use DIGITS=4, DWELL=4, BLANK=1.
- **Reset:** assert `rst` mid-slot → `an`=4'b1111, `num`=0, `frame_done`=0 in the same cycle, before any clock edge; after release, digit 0 slot starts with `an`=1111 for 1 cycle, then 1110 for 3 cycles.
- **Deferred load:** pulse `load` with `value`=16'h1234 at cycle 2 after reset → frame 0 shows all zeros. `frame_done` is high at cycle 15. Cycles 16–19: `num`=4, `an`=1111,1110,1110,1110. Cycles 20–23: `num`=3 with `an[1]` low.
- **Last load wins:** loads of 16'hAAAA then 16'h5555 within one frame → next frame shows `num`=5 on every digit; A is never displayed.
- **Boundary coincidence:** `load` 16'hBEEF in the same cycle as `frame_done` → the next cycle shows `num`=F on digit 0; an earlier pending value in that frame is discarded.
- **Reset mid-frame with pending:** load 16'h7777, then reset before the boundary → after release, `active` stays 0 and `num`=0 for the whole next frame.
- **LZB (macro defined):** `active`=16'h0030 → `an[3]` and `an[2]` stay 1 through their slots, digit 1 shows 3, digit 0 shows 0; `active`=0 → only `an[0]` ever goes low.
